// File: rtl/key_pkg.sv
// key_pkg: shared key-code definitions and default sizing for the keypad
// event path (scanner -> key_event_queue -> lock controller).
//   KEY_W            width of one decoded key code
//   KEY_*            key code constants produced by the scanner
//   DEF_DEPTH        default queue depth
//   DEF_TIMEOUT_CYC  default idle flush time (5 s of CLK_HZ)
//   DEF_TMR_W        idle counter width able to hold DEF_TIMEOUT_CYC
package key_pkg;

    localparam int KEY_W = 4;

    typedef logic [KEY_W-1:0] key_t;

    localparam key_t KEY_0    = 4'h0;
    localparam key_t KEY_1    = 4'h1;
    localparam key_t KEY_2    = 4'h2;
    localparam key_t KEY_3    = 4'h3;
    localparam key_t KEY_4    = 4'h4;
    localparam key_t KEY_5    = 4'h5;
    localparam key_t KEY_6    = 4'h6;
    localparam key_t KEY_7    = 4'h7;
    localparam key_t KEY_8    = 4'h8;
    localparam key_t KEY_9    = 4'h9;
    localparam key_t KEY_ENT  = 4'hA;
    localparam key_t KEY_CLR  = 4'hB;
    localparam key_t KEY_NONE = 4'hF;

    localparam int DEF_DEPTH       = 4;
    localparam int CLK_HZ          = 50_000_000;
    localparam int IDLE_SEC        = 5;
    localparam int DEF_TIMEOUT_CYC = CLK_HZ * IDLE_SEC;
    localparam int DEF_TMR_W       = 28;

endpackage

// File: rtl/key_event_queue_idle_timer.sv
// idle_timer: counts cycles while 'run' is high and raises 'expire' on the
// cycle the count reaches TIMEOUT_CYC-1, so the owner can act on the next edge.
//   clk     system clock
//   rst_n   asynchronous active-low reset
//   clr     restart the count from zero
//   run     count this cycle
//   expire  high for the cycle in which the timeout is reached
module idle_timer #(
    parameter int TIMEOUT_CYC = key_pkg::DEF_TIMEOUT_CYC,
    parameter int TMR_W       = key_pkg::DEF_TMR_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic run,
    output logic expire
);
    import key_pkg::*;

    localparam logic [TMR_W-1:0] LAST = TMR_W'(TIMEOUT_CYC - 1);

    logic [TMR_W-1:0] cnt_q, cnt_d;

    assign expire = run && (cnt_q == LAST);

    // Expiry restarts the count so a fresh timeout period follows a flush.
    always_comb begin
        cnt_d = cnt_q;
        if (clr || expire) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/key_event_queue.sv
// key_event_queue: first-word-fall-through queue between the keypad scanner
// and the lock controller, with overflow reporting and an idle flush.
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   key_in       key code from scanner
//   key_in_vld   1-cycle strobe, key_in valid
//   key_out      head-of-queue code (0 while empty)
//   key_out_vld  queue non-empty
//   key_out_rdy  consumer accepts head this cycle
//   level        current occupancy
//   ovf          1-cycle pulse, key dropped because queue full
//   flush        1-cycle pulse, idle timeout emptied queue
module key_event_queue #(
    parameter int KEY_W       = key_pkg::KEY_W,
    parameter int DEPTH       = key_pkg::DEF_DEPTH,
    parameter int TIMEOUT_CYC = key_pkg::DEF_TIMEOUT_CYC,
    parameter int TMR_W       = key_pkg::DEF_TMR_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [KEY_W-1:0]       key_in,
    input  logic                   key_in_vld,
    output logic [KEY_W-1:0]       key_out,
    output logic                   key_out_vld,
    input  logic                   key_out_rdy,
    output logic [$clog2(DEPTH):0] level,
    output logic                   ovf,
    output logic                   flush
);
    import key_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [KEY_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             flush_q, flush_d;

    logic empty, full, pop, push;
    logic tmr_clr, tmr_run, expire;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == FULL_CNT);
    assign pop   = !empty && key_out_rdy;
    // A pop in the same cycle frees the slot, so a full queue still accepts.
    assign push  = key_in_vld && (!full || pop);

    // An accepted push restarts the timer, so expiry never coincides with one.
    assign tmr_clr = push || empty;
    assign tmr_run = !empty && !push;

    idle_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .TMR_W       (TMR_W)
    ) u_idle_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (tmr_clr),
        .run    (tmr_run),
        .expire (expire)
    );

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        ovf_d    = key_in_vld && full && !pop;
        flush_d  = expire;
        if (expire) begin
            // Flush overrides any pop presented in the same cycle.
            rd_ptr_d = wr_ptr_q;
            cnt_d    = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                cnt_d = cnt_q + 1'b1;
            end else if (pop && !push) begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            flush_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            flush_q  <= flush_d;
        end
    end

    // Storage carries no reset; contents are only observed while non-empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= key_in;
        end
    end

    assign key_out     = empty ? '0 : mem_q[rd_ptr_q];
    assign key_out_vld = !empty;
    assign level       = cnt_q;
    assign ovf         = ovf_q;
    assign flush       = flush_q;

endmodule

// File: tb/tb_key_event_queue.sv
module tb_key_event_queue;

    localparam int DEPTH = 4;
    localparam int TOUT  = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] key_in = 4'h0;
    logic       key_in_vld = 1'b0;
    logic       key_out_rdy = 1'b0;
    logic [3:0] key_out;
    logic       key_out_vld;
    logic [2:0] level;
    logic       ovf;
    logic       flush;

    key_event_queue #(
        .KEY_W       (4),
        .DEPTH       (DEPTH),
        .TIMEOUT_CYC (TOUT),
        .TMR_W       (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_in      (key_in),
        .key_in_vld  (key_in_vld),
        .key_out     (key_out),
        .key_out_vld (key_out_vld),
        .key_out_rdy (key_out_rdy),
        .level       (level),
        .ovf         (ovf),
        .flush       (flush)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: an ordered list of held keys plus an idle-cycle count.
    int mq[$];
    int exp_q[$];
    int act_q[$];
    int tmr = 0;
    bit e_ovf = 1'b0;
    bit e_flush = 1'b0;
    bit pend_v = 1'b0;
    int pend_k = 0;

    task automatic chk(input string nm, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, want, $time);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        exp_q.delete();
        act_q.delete();
        tmr     = 0;
        e_ovf   = 1'b0;
        e_flush = 1'b0;
        pend_v  = 1'b0;
    endtask

    task automatic model_step();
        int n;
        bit full_m, pop_m, push_m, expire_m;
        if (!rst_n) begin
            model_clear();
            return;
        end
        n        = mq.size();
        full_m   = (n == DEPTH);
        pop_m    = (n != 0) && key_out_rdy;
        push_m   = key_in_vld && (!full_m || pop_m);
        expire_m = (n != 0) && !push_m && (tmr == TOUT - 1);
        e_ovf    = key_in_vld && full_m && !pop_m;
        e_flush  = expire_m;
        if (expire_m) begin
            mq.delete();
            tmr = 0;
        end else begin
            if (pop_m) exp_q.push_back(mq.pop_front());
            if (push_m) mq.push_back(int'(key_in));
            tmr = (push_m || n == 0) ? 0 : tmr + 1;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Monitor: records each handshake the DUT presents and checks it against
    // the scoreboard once the following cycle confirms no flush swallowed it.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (pend_v && !flush) act_q.push_back(pend_k);
                pend_v = 1'b0;
                while (act_q.size() != 0 && exp_q.size() != 0)
                    chk("pop_order", act_q.pop_front(), exp_q.pop_front());
                chk("level", int'(level), mq.size());
                chk("key_out_vld", int'(key_out_vld), int'(mq.size() != 0));
                chk("ovf", int'(ovf), int'(e_ovf));
                chk("flush", int'(flush), int'(e_flush));
                if (mq.size() != 0) chk("head", int'(key_out), mq[0]);
                if (key_out_vld && key_out_rdy) begin
                    pend_v = 1'b1;
                    pend_k = int'(key_out);
                end
            end
        end
    end

    task automatic step(input bit v, input int k, input bit r);
        key_in_vld  = v;
        key_in      = 4'(k);
        key_out_rdy = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int vp, rp;
        #1;
        chk("rst_level", int'(level), 0);
        chk("rst_vld", int'(key_out_vld), 0);
        chk("rst_key", int'(key_out), 0);
        chk("rst_ovf", int'(ovf), 0);
        chk("rst_flush", int'(flush), 0);
        step(0, 0, 0);
        step(0, 0, 0);
        rst_n = 1'b1;
        step(0, 0, 0);

        // single push, latency 1
        step(1, 3, 0);
        chk("t1_key", int'(key_out), 3);
        chk("t1_vld", int'(key_out_vld), 1);
        chk("t1_level", int'(level), 1);
        chk("t1_ovf", int'(ovf), 0);
        step(0, 0, 1);
        chk("t1_drain", int'(level), 0);

        // overflow
        for (int k = 1; k <= 4; k++) step(1, k, 0);
        step(1, 5, 0);
        chk("t2_level", int'(level), 4);
        chk("t2_ovf", int'(ovf), 1);
        step(0, 0, 0);
        chk("t2_ovf_end", int'(ovf), 0);
        repeat (4) step(0, 0, 1);
        chk("t2_empty", int'(level), 0);

        // push and pop at full
        for (int k = 1; k <= 4; k++) step(1, k, 0);
        step(1, 6, 1);
        chk("t3_ovf", int'(ovf), 0);
        chk("t3_level", int'(level), 4);
        chk("t3_head", int'(key_out), 2);
        repeat (4) step(0, 0, 1);

        // idle timeout
        step(1, 7, 0);
        repeat (TOUT - 1) step(0, 0, 0);
        chk("t4_noflush", int'(flush), 0);
        chk("t4_hold", int'(level), 1);
        step(0, 0, 0);
        chk("t4_flush", int'(flush), 1);
        chk("t4_level", int'(level), 0);
        chk("t4_vld", int'(key_out_vld), 0);
        step(1, 8, 0);
        repeat (10) step(0, 0, 0);
        chk("t4_restart_level", int'(level), 1);
        chk("t4_restart_flush", int'(flush), 0);
        step(0, 0, 1);

        // timeout coinciding with a dropped push at full
        for (int k = 1; k <= 4; k++) step(1, k, 0);
        repeat (TOUT - 1) step(0, 0, 0);
        step(1, 9, 0);
        chk("t5_flush", int'(flush), 1);
        chk("t5_ovf", int'(ovf), 1);
        chk("t5_level", int'(level), 0);

        // pointer wrap
        for (int k = 0; k < 10; k++) begin
            step(1, k, 0);
            step(0, 0, 1);
        end
        for (int k = 10; k < 14; k++) step(1, k, 0);
        chk("t6_level", int'(level), 4);
        chk("t6_head", int'(key_out), 10);
        repeat (4) step(0, 0, 1);

        // randomized traffic in several density regimes
        for (int p = 0; p < 3; p++) begin
            vp = (p == 0) ? 50 : (p == 1) ? 30 : 5;
            rp = (p == 0) ? 60 : (p == 1) ? 20 : 3;
            repeat (250)
                step($urandom_range(0, 99) < vp, int'($urandom_range(0, 15)),
                     $urandom_range(0, 99) < rp);
        end
        repeat (6) step(0, 0, 1);
        step(0, 0, 0);

        // asynchronous reset mid-burst
        for (int k = 1; k <= 3; k++) step(1, k, 0);
        step(0, 0, 0);
        chk("t7_pre_level", int'(level), 3);
        #2;
        rst_n = 1'b0;
        model_clear();
        #1;
        chk("t7_level", int'(level), 0);
        chk("t7_vld", int'(key_out_vld), 0);
        chk("t7_ovf", int'(ovf), 0);
        chk("t7_flush", int'(flush), 0);
        step(0, 0, 0);
        step(0, 0, 0);
        rst_n = 1'b1;
        step(1, 11, 0);
        chk("t7_post_key", int'(key_out), 11);
        chk("t7_post_level", int'(level), 1);
        step(0, 0, 1);
        step(0, 0, 0);
        step(0, 0, 0);

        chk("sb_exp_left", exp_q.size(), 0);
        chk("sb_act_left", act_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
